// File: rtl/ser_word_aligner.sv
// Serial lane receive aligner: hunts for the sync word, confirms word phase over
// consecutive boundaries, then delivers aligned words and drops lock on sustained slips.
module ser_word_aligner #(
   parameter int unsigned          Nbits_32     = 32,
   parameter logic [Nbits_32-1:0]  SYNC_WORD    = 32'hEAAAAAAA,
   parameter int unsigned          LOCK_COUNT   = 4,
   parameter int unsigned          UNLOCK_COUNT = 4
) (
   input  logic                clock,
   input  logic                rst_b,
   input  logic                ser_in,
   input  logic                resync,
   output logic [Nbits_32-1:0] data_out,
   output logic                data_valid,
   output logic                is_sync,
   output logic                locked,
   output logic                lock_lost,
   output logic [1:0]          align_state
);
   localparam int unsigned    BCW      = $clog2(Nbits_32);
   localparam int unsigned    CW       = 4;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(Nbits_32 - 1);
   localparam logic [CW-1:0]  LOCK_N   = CW'(LOCK_COUNT);
   localparam logic [CW-1:0]  UNLOCK_N = CW'(UNLOCK_COUNT);
   localparam bit             LOCK_ONE = (LOCK_COUNT == 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e              state_q;
   logic [Nbits_32-1:0] sr_q, sr_d, data_out_q;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]       match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
   logic                off_hit_q, data_valid_q, is_sync_q, locked_q, lock_lost_q;
   logic                match_c, boundary_c, drop_c;

   assign sr_d        = {sr_q[Nbits_32-2:0], ser_in};
   assign bit_cnt_d   = bit_cnt_q + BCW'(1);
   assign match_cnt_d = match_cnt_q + CW'(1);
   assign match_c     = (sr_q == SYNC_WORD);
   assign boundary_c  = (state_q != HUNT) && (bit_cnt_q == LAST_BIT);

   // Slip score at a boundary: an aligned sync clears it, an offset sync since the last boundary adds one
   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (match_c) begin
         miss_cnt_d = '0;
      end else if (off_hit_q) begin
         miss_cnt_d = miss_cnt_q + CW'(1);
      end
   end

   assign drop_c = (state_q == LOCKED) && boundary_c && (miss_cnt_d >= UNLOCK_N);

   always_ff @(posedge clock or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         off_hit_q    <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         is_sync_q    <= 1'b0;
         locked_q     <= 1'b0;
         lock_lost_q  <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         data_valid_q <= 1'b0;
         lock_lost_q  <= 1'b0;
         if (resync) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            off_hit_q   <= 1'b0;
            locked_q    <= 1'b0;
            is_sync_q   <= 1'b0;
         end else begin
            unique case (state_q)
               HUNT: begin
                  off_hit_q  <= 1'b0;
                  miss_cnt_q <= '0;
                  if (match_c) begin
                     bit_cnt_q   <= '0;
                     match_cnt_q <= CW'(1);
                     if (LOCK_ONE) begin
                        state_q      <= LOCKED;
                        locked_q     <= 1'b1;
                        data_out_q   <= sr_q;
                        is_sync_q    <= 1'b1;
                        data_valid_q <= 1'b1;
                     end else begin
                        state_q <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (boundary_c) begin
                     if (!match_c) begin
                        state_q     <= HUNT;
                        match_cnt_q <= '0;
                     end else begin
                        match_cnt_q <= match_cnt_d;
                        // The confirming sync word is delivered like any locked word
                        if (match_cnt_d >= LOCK_N) begin
                           state_q      <= LOCKED;
                           locked_q     <= 1'b1;
                           data_out_q   <= sr_q;
                           is_sync_q    <= 1'b1;
                           data_valid_q <= 1'b1;
                        end
                     end
                  end
               end
               LOCKED: begin
                  if (!boundary_c) begin
                     if (match_c) begin
                        off_hit_q <= 1'b1;
                     end
                  end else begin
                     off_hit_q <= 1'b0;
                     if (drop_c) begin
                        state_q     <= HUNT;
                        locked_q    <= 1'b0;
                        lock_lost_q <= 1'b1;
                        miss_cnt_q  <= '0;
                        match_cnt_q <= '0;
                     end else begin
                        miss_cnt_q   <= miss_cnt_d;
                        data_out_q   <= sr_q;
                        is_sync_q    <= match_c;
                        data_valid_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign is_sync     = is_sync_q;
   assign locked      = locked_q;
   assign lock_lost   = lock_lost_q;
   assign align_state = state_q;

endmodule
